// File: rtl/shift_issue_stage.sv
// Two-stage issue/retire wrapper around an external combinational one-hot shifter.
// Stage 1 registers the op and its one-hot select; stage 2 holds the shaped result until writeback accepts.
module shift_issue_stage #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_data,
    input  logic [4:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      sh_sel,
    output logic [31:0]      sh_din,
    input  logic [31:0]      sh_left,
    input  logic [31:0]      sh_right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_RSV = 2'b10,
        OP_SRA = 2'b11
    } shift_op_e;

    logic             s1_valid_q, s1_valid_d;
    shift_op_e        s1_op_q, s1_op_d;
    logic [4:0]       s1_shamt_q, s1_shamt_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [31:0]      sh_sel_q, sh_sel_d;
    logic [31:0]      sh_din_q, sh_din_d;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_err_q, out_err_d;

    logic             s2_free;
    logic             accept;
    logic             advance;
    logic [31:0]      sra_fill;
    logic [31:0]      result;
    logic             result_err;

    // Stage 2 can take a new op when empty or when its current result leaves this cycle.
    assign s2_free  = !out_valid_q || out_ready;
    assign in_ready = !rst && (!s1_valid_q || s2_free);
    assign accept   = in_valid && in_ready;
    assign advance  = s1_valid_q && s2_free;

    // SRA reuses the logical right shift and ORs in the sign bits that it shifted out.
    assign sra_fill = sh_din_q[31] ? ~(32'hFFFF_FFFF >> s1_shamt_q) : '0;

    always_comb begin
        result     = sh_din_q;
        result_err = 1'b0;
        unique case (s1_op_q)
            OP_SLL:  result = sh_left;
            OP_SRL:  result = sh_right;
            OP_SRA:  result = sh_right | sra_fill;
            default: result_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_shamt_d = s1_shamt_q;
        s1_tag_d   = s1_tag_q;
        sh_sel_d   = sh_sel_q;
        sh_din_d   = sh_din_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = shift_op_e'(in_op);
            s1_shamt_d = in_shamt;
            s1_tag_d   = in_tag;
            sh_sel_d   = 32'd1 << in_shamt;
            sh_din_d   = in_data;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_err_d   = out_err_q;
        if (advance) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
            out_tag_d   = s1_tag_q;
            out_err_d   = result_err;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_SLL;
            s1_shamt_q  <= '0;
            s1_tag_q    <= '0;
            sh_sel_q    <= '0;
            sh_din_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_tag_q    <= s1_tag_d;
            sh_sel_q    <= sh_sel_d;
            sh_din_q    <= sh_din_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_err_q   <= out_err_d;
        end
    end

    assign sh_sel    = sh_sel_q;
    assign sh_din    = sh_din_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage; the external shifter is modelled from sh_sel/sh_din.
module tb_shift_issue_stage;

    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_data;
    logic [4:0]       in_shamt;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      sh_sel;
    logic [31:0]      sh_din;
    logic [31:0]      sh_left;
    logic [31:0]      sh_right;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    int total = 0;
    int bad   = 0;

    shift_issue_stage #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .sh_sel    (sh_sel),
        .sh_din    (sh_din),
        .sh_left   (sh_left),
        .sh_right  (sh_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Shifter model: amount is the index of the set bit in the one-hot select.
    logic [4:0] sh_idx;
    always_comb begin
        sh_idx = '0;
        for (int i = 0; i < 32; i++)
            if (sh_sel[i]) sh_idx = 5'(i);
    end
    assign sh_left  = sh_din << sh_idx;
    assign sh_right = sh_din >> sh_idx;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] data,
                         input logic [4:0] shamt, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_shamt = shamt;
        in_tag   = tag;
    endtask

    // Single op with out_ready high: result must appear one edge after accept.
    task automatic issue_one(input string name, input logic [1:0] op, input logic [31:0] data,
                             input logic [4:0] shamt, input logic [TAG_W-1:0] tag,
                             input logic [31:0] exp_data, input logic exp_err);
        drive(op, data, shamt, tag);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_data"}, out_data, exp_data);
        chk({name, "_tag"}, 32'(out_tag), 32'(tag));
        chk({name, "_err"}, 32'(out_err), 32'(exp_err));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = '0;
        in_shamt  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sh_sel", sh_sel, 32'd0);
        chk("rst_sh_din", sh_din, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // SLL 1 by 31 with latency check
        drive(2'b00, 32'h0000_0001, 5'd31, 5'd3);
        tick();
        in_valid = 1'b0;
        chk("sll31_not_yet_valid", 32'(out_valid), 32'd0);
        chk("sll31_sh_sel", sh_sel, 32'h8000_0000);
        chk("sll31_sh_din", sh_din, 32'h0000_0001);
        tick();
        chk("sll31_valid", 32'(out_valid), 32'd1);
        chk("sll31_data", out_data, 32'h8000_0000);
        chk("sll31_tag", 32'(out_tag), 32'd3);
        chk("sll31_err", 32'(out_err), 32'd0);

        issue_one("sra_neg4",  2'b11, 32'h8000_0000, 5'd4,  5'd4,  32'hF800_0000, 1'b0);
        issue_one("srl_neg4",  2'b01, 32'h8000_0000, 5'd4,  5'd5,  32'h0800_0000, 1'b0);
        issue_one("sra_pos4",  2'b11, 32'h7000_0000, 5'd4,  5'd6,  32'h0700_0000, 1'b0);
        issue_one("rsv",       2'b10, 32'hDEAD_BEEF, 5'd5,  5'd7,  32'hDEAD_BEEF, 1'b1);
        issue_one("sll_sh0",   2'b00, 32'h8765_4321, 5'd0,  5'd8,  32'h8765_4321, 1'b0);
        issue_one("srl_sh0",   2'b01, 32'h8765_4321, 5'd0,  5'd9,  32'h8765_4321, 1'b0);
        issue_one("sra_sh0",   2'b11, 32'h8765_4321, 5'd0,  5'd10, 32'h8765_4321, 1'b0);
        issue_one("sra_sh31",  2'b11, 32'h8000_0001, 5'd31, 5'd11, 32'hFFFF_FFFF, 1'b0);
        issue_one("srl_sh31",  2'b01, 32'h8000_0000, 5'd31, 5'd12, 32'h0000_0001, 1'b0);
        issue_one("sra_mixed", 2'b11, 32'hC000_0F00, 5'd8,  5'd13, 32'hFFC0_000F, 1'b0);

        // Eight back-to-back SLLs of 3 by i, tags 16..23
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(2'b00, 32'h0000_0003, 5'(i), 5'(16 + i));
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i > 0) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
                chk("b2b_tag", 32'(out_tag), 32'(15 + i));
                chk("b2b_data", out_data, 32'h0000_0003 << (i - 1));
            end
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_last_valid", 32'(out_valid), 32'd1);
        chk("b2b_last_tag", 32'(out_tag), 32'd23);
        chk("b2b_last_data", out_data, 32'h0000_0180);
        tick();
        chk("b2b_drained", 32'(out_valid), 32'd0);

        // Backpressure: three SRLs offered while writeback stalls for five edges
        out_ready = 1'b0;
        drive(2'b01, 32'hF000_0000, 5'd4, 5'd20);
        chk("bp_a_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(2'b01, 32'hF000_0000, 5'd8, 5'd21);
        chk("bp_b_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(2'b01, 32'hF000_0000, 5'd12, 5'd22);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_tag", 32'(out_tag), 32'd20);
            chk("bp_hold_data", out_data, 32'h0F00_0000);
            chk("bp_hold_err", 32'(out_err), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_b_tag", 32'(out_tag), 32'd21);
        chk("bp_b_data", out_data, 32'h00F0_0000);
        tick();
        chk("bp_c_valid", 32'(out_valid), 32'd1);
        chk("bp_c_tag", 32'(out_tag), 32'd22);
        chk("bp_c_data", out_data, 32'h000F_0000);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset with two ops in flight
        out_ready = 1'b0;
        drive(2'b00, 32'h0000_00FF, 5'd4, 5'd25);
        tick();
        drive(2'b00, 32'h0000_00FF, 5'd8, 5'd26);
        tick();
        in_valid = 1'b0;
        chk("inflight_valid", 32'(out_valid), 32'd1);
        chk("inflight_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_stale_valid", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
